uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
//  Serial-to-parallel UART receiver for the USB-uart bridge: samples the host
//  line RxD_ser with a 16x oversample tick and recovers 8N1 frames. Delivers
//  each byte as RxD_par plus a one-cycle RxD_start strobe, which is the exact
//  input handshake of the transmit stage.
//  Also flags framing errors and reports busy.
// PARAMETERS
//  OVERSAMPLE   16  OversampleTick pulses per bit; even, >=8
//  DATA_BITS    8   data bits per frame, LSB first; no parity, 1 stop bit
//  SYNC_STAGES  2   flip-flops in the RxD_ser metastability synchroniser, >=2
// PORTS
//  sys_clk         in   1          system clock; all logic on its rising edge
//  sys_rst_n       in   1          asynchronous, active-low reset
//  OversampleTick  in   1          1-cycle pulse at OVERSAMPLE x baud rate
//  RxD_ser         in   1          asynchronous serial input; idles high
//  RxD_par         out  DATA_BITS  last good byte; held until next good frame
//  RxD_start       out  1          1-cycle strobe: RxD_par newly valid
//  RxD_frame_err   out  1          1-cycle strobe: stop bit sampled low
//  RxD_busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): synchroniser FFs = 1, state = IDLE,
//   counters = 0, RxD_par = 0, RxD_start = RxD_frame_err = RxD_busy = 0.
//  rx_s = synchronised RxD_ser. Only cycles with OversampleTick=1 advance
//   the FSM. tick_cnt counts ticks within a bit, 0..OVERSAMPLE-1.
//  Bit value = majority of rx_s at tick_cnt = M-1, M, M+1, where
//   M = OVERSAMPLE/2.
//  FSM:
//   IDLE  : on tick with rx_s=0 -> START, tick_cnt=0.
//   START : tick_cnt increments. At tick_cnt=M+1, evaluate the vote:
//           1 -> IDLE (false start, no strobe); 0 -> continue.
//           At tick_cnt=OVERSAMPLE-1 -> DATA, tick_cnt=0, bit_cnt=0.
//   DATA  : at tick_cnt=M+1, shift the voted bit in at the MSB (shift right).
//           This gives LSB-first order.
//           At tick_cnt=OVERSAMPLE-1: bit_cnt++. After DATA_BITS bits -> STOP.
//   STOP  : at tick_cnt=M+1, evaluate the vote:
//           1 -> RxD_par <= shift reg, RxD_start=1 for the next sys_clk
//                cycle only, -> IDLE.
//           0 -> RxD_frame_err=1 for one cycle, RxD_par unchanged, -> BREAK.
//   BREAK : wait for a tick with rx_s=1 -> IDLE.
//           A held-low line (break) yields exactly one frame_err.
//  Early return to IDLE at stop mid-bit allows back-to-back frames with
//   1 stop bit at +/-3% baud error.
//  Latency: RxD_start is asserted in the cycle after the sampling tick
//   (tick_cnt=M+1 of the stop bit), plus SYNC_STAGES cycles of input delay.
//  RxD_start and RxD_frame_err never assert in the same cycle.
//  No backpressure: the consumer must accept the byte on the RxD_start cycle.
//  Ticks closer than 1 sys_clk apart are illegal.
//  OversampleTick high for multiple cycles counts as multiple ticks.
//  Reset mid-frame discards the partial byte, and no strobe is emitted.
//  RxD_ser changes between ticks are ignored except via the vote.
// TESTING
//  T1 Reset, idle high 20 bit-times -> all outputs 0, busy 0, no strobes.
//  T2 Send 0x55 (tick every 4 sys_clk) -> exactly one RxD_start, RxD_par=8'h55;
//     busy falls with the strobe.
//  T3 Glitch: RxD_ser low for 4 ticks, then high -> back to IDLE, no strobe,
//     RxD_par unchanged.
//  T4 Back-to-back 0xA3, 0x0F, 0xFF, 0x00 with 1 stop bit, at +3% and -3% baud
//     -> 4 strobes with matching values, in order.
//  T5 Stop bit forced 0 on 0x3C -> one RxD_frame_err, no RxD_start,
//     RxD_par keeps the prior byte. Line held low 3 frames -> no extra error.
//     Next good 0x81 received.
//  T6 Assert sys_rst_n low mid-DATA of 0xC6, release, send 0x42
//     -> only 0x42 is strobed.

Source files
------------

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 16x-oversampled majority-vote bit recovery with
// one-cycle byte and framing-error strobes for the bridge transmit stage.
module uart_rx_deser #(
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 OversampleTick,
   input  logic                 RxD_ser,
   output logic [DATA_BITS-1:0] RxD_par,
   output logic                 RxD_start,
   output logic                 RxD_frame_err,
   output logic                 RxD_busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] VOTE_LO  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] VOTE_MID = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] VOTE_HI  = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   rx_s;
   logic [TICK_W-1:0]      tick_cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic                   samp_lo;
   logic                   samp_mid;
   logic                   vote;
   logic                   at_vote;
   logic                   at_end;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   load_byte;
   logic                   flag_err;

   // Synchroniser idles high so reset release never looks like a start bit.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], RxD_ser};
      end
   end

   assign rx_s    = sync_ff[SYNC_STAGES-1];
   assign at_vote = (tick_cnt == VOTE_HI);
   assign at_end  = (tick_cnt == TICK_END);
   assign vote    = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (OversampleTick) begin
         unique case (state)
            S_IDLE:  if (!rx_s) state_next = S_START;
            S_START: begin
               if (at_vote && vote) begin
                  state_next = S_IDLE;
               end else if (at_end) begin
                  state_next = S_DATA;
               end
            end
            S_DATA:  if (at_end && bit_cnt == LAST_BIT) state_next = S_STOP;
            S_STOP:  if (at_vote) state_next = vote ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      RxD_busy  = (state != S_IDLE);
      load_byte = 1'b0;
      flag_err  = 1'b0;
      if (OversampleTick && state == S_STOP && at_vote) begin
         load_byte = vote;
         flag_err  = ~vote;
      end
   end

   // The tick counter only runs inside a frame; IDLE and BREAK hold it at zero
   // so the tick that detects the start edge always begins a fresh bit period.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         samp_lo   <= 1'b1;
         samp_mid  <= 1'b1;
         shift_reg <= '0;
      end else if (OversampleTick) begin
         if (state == S_IDLE || state == S_BREAK || at_end) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         if (tick_cnt == VOTE_LO) begin
            samp_lo <= rx_s;
         end
         if (tick_cnt == VOTE_MID) begin
            samp_mid <= rx_s;
         end
         if (state == S_START) begin
            bit_cnt <= '0;
         end else if (state == S_DATA && at_end) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == S_DATA && at_vote) begin
            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         RxD_par       <= '0;
         RxD_start     <= 1'b0;
         RxD_frame_err <= 1'b0;
      end else begin
         RxD_start     <= load_byte;
         RxD_frame_err <= flag_err;
         if (load_byte) begin
            RxD_par <= shift_reg;
         end
      end
   end

   strobe_exclusive: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
      !(RxD_start && RxD_frame_err));

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed frames push expected events,
// an independent monitor pops and compares on every strobe.
module tb_uart_rx_deser;

   localparam int BIT      = 64;
   localparam int BIT_FAST = 62;
   localparam int BIT_SLOW = 66;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       OversampleTick;
   logic       RxD_ser;
   logic [7:0] RxD_par;
   logic       RxD_start;
   logic       RxD_frame_err;
   logic       RxD_busy;

   exp_t       exp_q[$];
   logic [7:0] last_good;
   int         checks;
   int         failures;

   uart_rx_deser #(.OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .OversampleTick(OversampleTick),
      .RxD_ser       (RxD_ser),
      .RxD_par       (RxD_par),
      .RxD_start     (RxD_start),
      .RxD_frame_err (RxD_frame_err),
      .RxD_busy      (RxD_busy)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // One oversample tick every fourth clock, driven on the falling edge.
   initial begin
      OversampleTick = 1'b0;
      forever begin
         repeat (3) @(negedge sys_clk);
         OversampleTick = 1'b1;
         @(negedge sys_clk);
         OversampleTick = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive_bit(input logic value, input int clks);
      RxD_ser = value;
      repeat (clks) @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input int clks, input logic stop_val);
      if (stop_val) begin
         exp_q.push_back({1'b0, data});
         last_good = data;
      end else begin
         exp_q.push_back({1'b1, last_good});
      end
      drive_bit(1'b0, clks);
      for (int i = 0; i < 8; i++) drive_bit(data[i], clks);
      drive_bit(stop_val, clks);
   endtask

   always @(negedge sys_clk) begin
      if (sys_rst_n && (RxD_start || RxD_frame_err)) begin
         exp_t e;
         if (RxD_start && RxD_frame_err) begin
            checks++;
            failures++;
            $display("[TB] FAIL strobe_overlap actual=both required=one");
         end
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_strobe actual=start%0b/err%0b par=0x%0h required=none",
                     RxD_start, RxD_frame_err, RxD_par);
         end else begin
            e = exp_q.pop_front();
            check_output("event_is_err", 32'(RxD_frame_err), 32'(e.is_err));
            check_output("event_par", 32'(RxD_par), 32'(e.data));
            check_output("event_busy", 32'(RxD_busy), 32'(e.is_err));
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      last_good = 8'h00;
      sys_rst_n = 1'b0;
      RxD_ser   = 1'b1;
      repeat (5) @(negedge sys_clk);
      check_output("rst_par", 32'(RxD_par), 32'h0);
      check_output("rst_start", 32'(RxD_start), 32'h0);
      check_output("rst_err", 32'(RxD_frame_err), 32'h0);
      check_output("rst_busy", 32'(RxD_busy), 32'h0);
      sys_rst_n = 1'b1;

      $display("[TB] T1 idle line");
      repeat (20 * BIT) @(negedge sys_clk);
      check_output("t1_busy", 32'(RxD_busy), 32'h0);
      check_output("t1_par", 32'(RxD_par), 32'h0);
      check_output("t1_queue", 32'(exp_q.size()), 32'h0);

      $display("[TB] T2 single byte 0x55");
      fork
         send_frame(8'h55, BIT, 1'b1);
         begin
            repeat (3 * BIT) @(negedge sys_clk);
            check_output("t2_busy_mid", 32'(RxD_busy), 32'h1);
         end
      join
      drive_bit(1'b1, 2 * BIT);
      check_output("t2_queue", 32'(exp_q.size()), 32'h0);
      check_output("t2_par", 32'(RxD_par), 32'h55);

      $display("[TB] T3 start glitch");
      drive_bit(1'b0, 16);
      check_output("t3_busy_glitch", 32'(RxD_busy), 32'h1);
      drive_bit(1'b1, 3 * BIT);
      check_output("t3_busy", 32'(RxD_busy), 32'h0);
      check_output("t3_par", 32'(RxD_par), 32'h55);
      check_output("t3_queue", 32'(exp_q.size()), 32'h0);

      $display("[TB] T4 back-to-back at fast and slow baud");
      send_frame(8'hA3, BIT_FAST, 1'b1);
      send_frame(8'h0F, BIT_FAST, 1'b1);
      send_frame(8'hFF, BIT_FAST, 1'b1);
      send_frame(8'h00, BIT_FAST, 1'b1);
      drive_bit(1'b1, 2 * BIT);
      check_output("t4_fast_queue", 32'(exp_q.size()), 32'h0);
      send_frame(8'hA3, BIT_SLOW, 1'b1);
      send_frame(8'h0F, BIT_SLOW, 1'b1);
      send_frame(8'hFF, BIT_SLOW, 1'b1);
      send_frame(8'h00, BIT_SLOW, 1'b1);
      drive_bit(1'b1, 2 * BIT);
      check_output("t4_slow_queue", 32'(exp_q.size()), 32'h0);
      check_output("t4_par", 32'(RxD_par), 32'h00);

      $display("[TB] T5 framing error and break");
      send_frame(8'h3C, BIT, 1'b0);
      drive_bit(1'b0, 30 * BIT);
      check_output("t5_queue_err", 32'(exp_q.size()), 32'h0);
      check_output("t5_busy_break", 32'(RxD_busy), 32'h1);
      check_output("t5_par_held", 32'(RxD_par), 32'h00);
      drive_bit(1'b1, 2 * BIT);
      check_output("t5_busy_idle", 32'(RxD_busy), 32'h0);
      send_frame(8'h81, BIT, 1'b1);
      drive_bit(1'b1, 2 * BIT);
      check_output("t5_queue", 32'(exp_q.size()), 32'h0);
      check_output("t5_par", 32'(RxD_par), 32'h81);

      $display("[TB] T6 reset mid-frame");
      drive_bit(1'b0, BIT);
      drive_bit(1'b0, BIT);
      drive_bit(1'b1, BIT);
      drive_bit(1'b1, BIT);
      drive_bit(1'b0, BIT / 2);
      check_output("t6_busy_pre", 32'(RxD_busy), 32'h1);
      sys_rst_n = 1'b0;
      RxD_ser   = 1'b1;
      last_good = 8'h00;
      repeat (3) @(negedge sys_clk);
      check_output("t6_rst_busy", 32'(RxD_busy), 32'h0);
      check_output("t6_rst_par", 32'(RxD_par), 32'h0);
      sys_rst_n = 1'b1;
      drive_bit(1'b1, 3 * BIT);
      check_output("t6_idle_busy", 32'(RxD_busy), 32'h0);
      send_frame(8'h42, BIT, 1'b1);
      drive_bit(1'b1, 2 * BIT);
      check_output("t6_queue", 32'(exp_q.size()), 32'h0);
      check_output("t6_par", 32'(RxD_par), 32'h42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
